// File: rtl/tof_pll_cfg_ctrl.sv
// tof_pll_cfg_ctrl: programs the TOF clock PLL over SCLK/SDIN/LOAD and supervises lock; define TOF_PLL_AUTO_RELOCK_EN to reprogram automatically on lock loss
module tof_pll_cfg_ctrl #(
  parameter int unsigned SCLK_DIV     = 4,
  parameter int unsigned PWR_WAIT     = 1000,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned LOCK_FILTER  = 16,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [23:0] INIT_0       = 24'h34002D,
  parameter logic [23:0] INIT_1       = 24'h0481A4,
  parameter logic [23:0] INIT_2       = 24'h002C0A
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        pll_sclk_o,
  output logic        pll_sdin_o,
  output logic        pll_load_o,
  input  logic        pll_lock_i,
  input  logic        wr_req_i,
  input  logic [23:0] wr_data_i,
  output logic        wr_ack_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic        fail_o,
  output logic        lock_lost_o,
  output logic [1:0]  retry_cnt_o
);
  typedef enum logic [2:0] {PWR, SHIFT, LOAD, GAP, LOCKW, READY, FAIL} state_t;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, filt_q, filt_d;
  logic [23:0] sr_q, sr_d;
  logic [4:0] bit_q, bit_d;
  logic [1:0] idx_q, idx_d, retry_q, retry_d, sync_q, sync_d;
  logic rt_q, rt_d;
  logic sclk_q, sclk_d, sdin_q, sdin_d, load_q, load_d, ack_q, ack_d;
  logic busy_q, busy_d, ready_q, ready_d, fail_q, fail_d, lost_q, lost_d;
  logic lock_s, idle, relock, accept;

  assign lock_s = sync_q[1];
  assign idle   = state_q == READY || state_q == FAIL;
`ifdef TOF_PLL_AUTO_RELOCK_EN
  assign relock = state_q == READY && !lock_s;
`else
  assign relock = 1'b0;
`endif
  assign accept = idle && wr_req_i && !relock;

  assign pll_sclk_o  = sclk_q;
  assign pll_sdin_o  = sdin_q;
  assign pll_load_o  = load_q;
  assign wr_ack_o    = ack_q;
  assign busy_o      = busy_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign lock_lost_o = lost_q;
  assign retry_cnt_o = retry_q;

  // state, datapath and registered outputs; reset returns to the power-up wait
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PWR;
      cnt_q   <= '0;
      filt_q  <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      sync_q  <= '0;
      rt_q    <= 1'b0;
      sclk_q  <= 1'b0;
      sdin_q  <= 1'b0;
      load_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      sync_q  <= sync_d;
      rt_q    <= rt_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
      lost_q  <= lost_d;
    end
  end

  // sequencing: bit and word timing, lock qualification, retries and write arbitration
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    filt_d  = '0;
    sr_d    = sr_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    rt_d    = rt_q;
    sync_d  = {sync_q[0], pll_lock_i};
    case (state_q)
      PWR: if (cnt_q == PWR_WAIT - 1) begin
        state_d = SHIFT;
        cnt_d   = '0;
        sr_d    = INIT_0;
        idx_d   = '0;
        bit_d   = '0;
      end
      SHIFT: if (cnt_q == 2 * SCLK_DIV - 1) begin
        cnt_d = '0;
        sr_d  = {sr_q[22:0], 1'b0};
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd23) state_d = LOAD;
      end
      LOAD: if (cnt_q == 2 * SCLK_DIV - 1) begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: if (cnt_q == SCLK_DIV - 1) begin
        cnt_d = '0;
        bit_d = '0;
        if (!rt_q && idx_q != 2'd2) begin
          state_d = SHIFT;
          idx_d   = idx_q + 2'd1;
          sr_d    = idx_q == 2'd0 ? INIT_1 : INIT_2;
        end else state_d = LOCKW;
      end
      LOCKW: begin
        filt_d = lock_s ? filt_q + 32'd1 : '0;
        if (filt_d == LOCK_FILTER) begin
          state_d = READY;
          retry_d = '0;
          rt_d    = 1'b0;
        end else if (cnt_d == LOCK_TIMEOUT) begin
          cnt_d = '0;
          if (!rt_q && {30'd0, retry_q} < MAX_RETRY) begin
            state_d = SHIFT;
            retry_d = retry_q + 2'd1;
            idx_d   = '0;
            sr_d    = INIT_0;
          end else begin
            state_d = FAIL;
            rt_d    = 1'b0;
          end
        end
      end
      default: begin
        cnt_d = '0;
        if (relock) begin
          state_d = SHIFT;
          retry_d = '0;
          idx_d   = '0;
          sr_d    = INIT_0;
          bit_d   = '0;
          rt_d    = 1'b0;
        end else if (accept) begin
          state_d = SHIFT;
          retry_d = '0;
          sr_d    = wr_data_i;
          bit_d   = '0;
          rt_d    = 1'b1;
        end
      end
    endcase
  end

  // pin and status values decoded from the upcoming state so every output is a flop
  always_comb begin
    sclk_d  = state_d == SHIFT && cnt_d >= SCLK_DIV;
    sdin_d  = state_d == SHIFT && sr_d[23];
    load_d  = state_d == LOAD && cnt_d >= SCLK_DIV;
    ack_d   = accept;
    busy_d  = state_d != READY && state_d != FAIL;
    ready_d = state_d == READY && (state_q != READY || (ready_q && lock_s));
    fail_d  = state_d == FAIL;
    lost_d  = lost_q || (state_q == READY && !lock_s);
  end
endmodule

// File: doc/tof_pll_cfg_ctrl.md
Name: tof_pll_cfg_ctrl

Overview:
Sequencer that programs the TOF board clock PLL over its 3-wire serial interface (SCLK/SDIN/LOAD) and supervises lock.
- Init: after reset, shifts three fixed 24-bit init words, then waits for PLL lock, retrying on timeout.
- Runtime: afterwards, arbitrates a single runtime register-write port against re-initialisation.
- Status: reports ready/fail status to the bootloader control logic.

Parameters:
SCLK_DIV, 4, clk_i cycles per SCLK half-period (>=1)
PWR_WAIT, 1000, clk_i cycles idle after reset before first word
LOCK_TIMEOUT, 100000, clk_i cycles allowed from last LOAD to qualified lock
LOCK_FILTER, 16, consecutive synced-high lock samples required to qualify lock
MAX_RETRY, 3, init retries after lock timeout before FAIL
INIT_0, 24'h34002D, first init word
INIT_1, 24'h0481A4, second init word
INIT_2, 24'h002C0A, third init word

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-high
pll_sclk_o  out  1  PLL serial clock
pll_sdin_o  out  1  PLL serial data, MSB first
pll_load_o  out  1  PLL latch enable, high pulse after each word
pll_lock_i  in  1  PLL lock detect, asynchronous
wr_req_i  in  1  runtime write request, level, held until ack
wr_data_i  in  24  runtime word
wr_ack_o  out  1  one-cycle pulse when wr_data_i is captured
busy_o  out  1  sequence in progress
ready_o  out  1  PLL programmed and lock qualified
fail_o  out  1  retries exhausted or runtime write failed to lock
lock_lost_o  out  1  sticky: qualified lock dropped while READY
retry_cnt_o  out  2  retries used in current sequence

Behaviour:
- pll_lock_i is passed through a 2-flop synchroniser; all lock logic uses the synced value.
- Reset values: all pll_* = 0, wr_ack_o = 0, ready_o = 0, fail_o = 0, lock_lost_o = 0, retry_cnt_o = 0, busy_o = 1; state = PWR.
- Reset asserted mid-operation returns to PWR immediately; SCLK/LOAD drop low on the next edge.
- States: PWR, SHIFT, LOAD, GAP, LOCKW, READY, FAIL.
- PWR: count PWR_WAIT cycles, then load INIT_0 into the shift register, word index = 0, go to SHIFT.
- SHIFT, per bit, 2*SCLK_DIV cycles:
  - SDIN = current MSB for the whole bit.
  - SCLK low for the first SCLK_DIV cycles, high for the second SCLK_DIV cycles.
  - The register shifts left at bit end.
  - After bit 24, SCLK = 0 and SDIN = 0; go to LOAD.
- LOAD: one SCLK_DIV low setup period, then LOAD = 1 for SCLK_DIV cycles, then LOAD = 0; go to GAP.
- GAP: SCLK_DIV cycles all low.
  - If another init word remains (index < 2), load the next word and go to SHIFT.
  - Otherwise go to LOCKW with timer cleared.
- LOCKW:
  - Filter counter increments while synced lock = 1 and clears to 0 when it is 0.
  - Counter reaching LOCK_FILTER -> READY, retry_cnt_o cleared.
  - Timer reaching LOCK_TIMEOUT first:
    - retry_cnt_o < MAX_RETRY: increment, restart at INIT_0 in SHIFT (no PWR wait).
    - Otherwise: FAIL.
  - Filter completion and timeout on the same cycle: lock wins.
- READY: ready_o = 1, busy_o = 0.
  - A single synced-low lock sample sets lock_lost_o (sticky until reset) and clears ready_o; state stays READY (see option).
- FAIL: fail_o = 1, busy_o = 0, ready_o = 0.
- Runtime write: wr_req_i is accepted only in READY or FAIL, never while busy.
  - On acceptance: wr_ack_o pulses the same cycle wr_data_i is captured; fail_o and retry_cnt_o clear; busy_o = 1.
  - Then one SHIFT -> LOAD -> GAP of that word -> LOCKW.
  - Timeout after a runtime write goes to FAIL (no retry).
  - Runtime write while lock_lost_o = 1 is allowed and does not clear lock_lost_o.
- wr_req_i asserted during busy: held pending, acknowledged on the first cycle of READY/FAIL.
- Outputs are registered, no combinational path to pll_* pins.

Optional Feature:
TOF_PLL_AUTO_RELOCK_EN:
- Defined: loss of lock in READY additionally restarts the full init sequence at INIT_0 (SHIFT, retry_cnt_o = 0, MAX_RETRY applies).
- Undefined: loss of lock only sets lock_lost_o and clears ready_o; no reprogramming.

Test Plan:
1. SCLK_DIV=2, PWR_WAIT=10, lock tied high after third LOAD:
   - First SCLK rise 12 cycles after rst_i release (10 PWR cycles + 2 sync/low).
   - SDIN bits of word 0 = 0,0,1,1,0,1,0,0,...,1,0,1,1,0,1.
   - 3 LOAD pulses of 2 cycles each.
   - ready_o = 1 LOCK_FILTER+2 cycles after lock rises.
2. Lock never asserts, LOCK_TIMEOUT=200, MAX_RETRY=3:
   - Four full 3-word sequences, retry_cnt_o steps 1, 2, 3.
   - Then fail_o = 1, busy_o = 0.
3. In READY, wr_req_i = 1 with wr_data_i = 24'hA5A5A5:
   - wr_ack_o one-cycle pulse.
   - One 24-bit shift with SDIN = 1,0,1,0,0,1,0,1 repeating.
   - One LOAD; ready_o returns after lock filter.
4. wr_req_i asserted during init word 1:
   - No ack until READY.
   - Init words unaltered; runtime word shifted afterwards.
5. Lock glitch low 1 cycle (after sync) in READY:
   - lock_lost_o = 1, ready_o = 0.
   - With TOF_PLL_AUTO_RELOCK_EN: INIT_0 shifting restarts.
6. rst_i pulsed mid-SHIFT of word 2:
   - All pll_* low next cycle, busy_o = 1.
   - Sequence restarts from PWR with INIT_0.
